// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - memory-stage load/store controller for the shared SRAM/UART bus
//
// Turns EX/MEM load/store requests into strobes on the shared RAM1/UART bus.
// It stalls the pipeline for the length of the access and returns the load
// result in memdata_out.
//
// Optional feature macro: MEM_CTRL_UART_EN.
//   Defined   : UART data at 0xBF00 and status at 0xBF01.
//   Undefined : every address goes to SRAM; uart_rdn/uart_wrn are tied high.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   mem_read, mem_write            request bits, held stable while stall=1
//   addr, wdata                    word address and store data
//   memdata_out                    registered load result
//   stall                          freezes PC, IF/ID, ID/EX and EX/MEM
//   ram_addr                       zero-extended addr
//   ram_data                       shared bidirectional data bus
//   ram_en_n, ram_oe_n, ram_we_n   SRAM strobes, active-low
//   uart_rdn, uart_wrn             UART strobes, active-low
//   uart_data_ready, uart_tbre,
//   uart_tsre                      UART status inputs

module mem_ctrl #(
  parameter int RAM_ADDR_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [15:0]           addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           memdata_out,
  output logic                  stall,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  inout  tri   [15:0]           ram_data,
  output logic                  ram_en_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic                  uart_rdn,
  output logic                  uart_wrn,
  input  logic                  uart_data_ready,
  input  logic                  uart_tbre,
  input  logic                  uart_tsre
);

`ifdef MEM_CTRL_UART_EN
  typedef enum logic [2:0] {IDLE, RD, WR, URD, UWR, UWAIT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, WR, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] memdata_q, memdata_d;
  logic [15:0] wdata_q;
  logic        drive_q, drive_d;
  logic        ram_en_n_q, ram_oe_n_q, ram_we_n_q;
  logic        busy;

  assign ram_addr = RAM_ADDR_W'(addr);

  // The bus is driven only from a register, so reset releases it at once.
  assign ram_data = drive_q ? wdata_q : 16'hzzzz;

`ifdef MEM_CTRL_UART_EN
  logic uart_rdn_q, uart_wrn_q;
  logic is_udata, is_ustat;

  assign is_udata = (addr == 16'hBF00);
  assign is_ustat = (addr == 16'hBF01);
  assign uart_rdn = uart_rdn_q;
  assign uart_wrn = uart_wrn_q;
`else
  // Status inputs are not used when the UART decode is compiled out.
  logic unused_uart;
  assign unused_uart = &{1'b0, uart_data_ready, uart_tbre, uart_tsre};
  assign uart_rdn = 1'b1;
  assign uart_wrn = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    memdata_d = memdata_q;
    case (state_q)
      IDLE: begin
`ifdef MEM_CTRL_UART_EN
        if (mem_write) begin
          // A write to the status address is silently dropped.
          if (is_udata)      state_d = UWR;
          else if (!is_ustat) state_d = WR;
        end else if (mem_read) begin
          if (is_udata)      state_d = URD;
          else if (is_ustat) memdata_d = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
          else               state_d = RD;
        end
`else
        if (mem_write)     state_d = WR;
        else if (mem_read) state_d = RD;
`endif
      end
      RD: begin
        memdata_d = ram_data;
        state_d   = DONE;
      end
      WR:      state_d = DONE;
`ifdef MEM_CTRL_UART_EN
      URD: begin
        memdata_d = {8'b0, ram_data[7:0]};
        state_d   = DONE;
      end
      UWR:     state_d = UWAIT;
      UWAIT:   if (uart_tbre && uart_tsre) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Data is held one cycle past the write strobe for hold time.
    drive_d = (state_d == WR) || (state_q == WR);
`ifdef MEM_CTRL_UART_EN
    drive_d = drive_d || (state_d == UWR) || (state_q == UWR);
`endif
  end

  always_comb begin
    busy = (state_q == RD) || (state_q == WR);
`ifdef MEM_CTRL_UART_EN
    busy = busy || (state_q == URD) || (state_q == UWR) || (state_q == UWAIT);
`endif
  end

  // Leaving IDLE is the only way a request asks for extra cycles; DONE never stalls.
  assign stall = rst && (busy || (state_q == IDLE && state_d != IDLE));

  // Strobes are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      memdata_q  <= 16'h0000;
      wdata_q    <= 16'h0000;
      drive_q    <= 1'b0;
      ram_en_n_q <= 1'b0;
      ram_oe_n_q <= 1'b1;
      ram_we_n_q <= 1'b1;
`ifdef MEM_CTRL_UART_EN
      uart_rdn_q <= 1'b1;
      uart_wrn_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      memdata_q  <= memdata_d;
      if (state_q == IDLE) wdata_q <= wdata;
      drive_q    <= drive_d;
      ram_oe_n_q <= (state_d != RD);
      ram_we_n_q <= (state_d != WR);
`ifdef MEM_CTRL_UART_EN
      ram_en_n_q <= (state_d == URD) || (state_d == UWR) || (state_d == UWAIT);
      uart_rdn_q <= (state_d != URD);
      uart_wrn_q <= (state_d != UWR);
`else
      ram_en_n_q <= 1'b0;
`endif
    end
  end

  assign memdata_out = memdata_q;
  assign ram_en_n    = ram_en_n_q;
  assign ram_oe_n    = ram_oe_n_q;
  assign ram_we_n    = ram_we_n_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] addr = 16'h0, wdata = 16'h0;
  logic [15:0] memdata_out;
  logic        stall;
  logic [17:0] ram_addr;
  tri   [15:0] ram_data;
  logic        ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b1, uart_tsre;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .memdata_out(memdata_out), .stall(stall),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en_n(ram_en_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .uart_rdn(uart_rdn),
    .uart_wrn(uart_wrn), .uart_data_ready(uart_data_ready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  // SRAM and UART bus models
  logic [15:0] mem [0:65535];
  logic        force_drv = 1'b0;
  logic        drv_en;
  logic [15:0] drv_val;
  logic [15:0] sram_q;
  assign sram_q  = mem[ram_addr[15:0]];
  assign drv_en  = force_drv || (!ram_en_n && !ram_oe_n) || !uart_rdn;
  assign drv_val = force_drv ? 16'h3C3C : (!uart_rdn ? 16'hA55A : sram_q);
  assign ram_data = drv_en ? drv_val : 16'hzzzz;

  always @(negedge clk) if (!ram_we_n && !ram_en_n) mem[ram_addr[15:0]] = ram_data;

  // Transmitter stays busy (tsre low) for 5 cycles from the write strobe.
  int  tx_cnt = 0;
  logic tsre_force_low = 1'b0;
  always @(negedge clk) begin
    if (!uart_wrn) tx_cnt = 5;
    else if (tx_cnt > 0) tx_cnt = tx_cnt - 1;
  end
  assign uart_tsre = (tx_cnt == 0) && !tsre_force_low;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          stall_n;
    int          we_n;
    int          oe_n;
    int          rdn_n;
    int          wrn_n;
    int          en_hi;
    logic        chk_bus;
    logic [15:0] bus;
    logic [15:0] md;
    logic        chk_done;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: accumulates strobe activity per request, closes it on the
  // cycle where stall is low, then checks memdata_out one cycle later.
  int          a_st, a_we, a_oe, a_rdn, a_wrn, a_en;
  logic [15:0] a_bus;
  logic        pend = 1'b0;
  exp_t        cur;

  always @(negedge clk) begin
    if (!rst) begin
      pend = 1'b0;
      a_st = 0; a_we = 0; a_oe = 0; a_rdn = 0; a_wrn = 0; a_en = 0; a_bus = 16'h0;
    end else begin
      if (pend) begin
        chk({cur.name, "_memdata"}, 32'(memdata_out), 32'(cur.md));
        pend = 1'b0;
      end
      if (!(mem_read || mem_write)) begin
        a_st = 0; a_we = 0; a_oe = 0; a_rdn = 0; a_wrn = 0; a_en = 0; a_bus = 16'h0;
      end else begin
        if (stall)     a_st++;
        if (!ram_we_n) begin a_we++; a_bus = ram_data; end
        if (!ram_oe_n) a_oe++;
        if (!uart_rdn) a_rdn++;
        if (!uart_wrn) begin a_wrn++; a_bus = ram_data; end
        if (ram_en_n)  a_en++;
        if (!stall) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk({cur.name, "_stall"}, a_st, cur.stall_n);
            chk({cur.name, "_we"},    a_we, cur.we_n);
            chk({cur.name, "_oe"},    a_oe, cur.oe_n);
            chk({cur.name, "_rdn"},   a_rdn, cur.rdn_n);
            chk({cur.name, "_wrn"},   a_wrn, cur.wrn_n);
            chk({cur.name, "_en_hi"}, a_en, cur.en_hi);
            if (cur.chk_bus)  chk({cur.name, "_bus"}, 32'(a_bus), 32'(cur.bus));
            if (cur.chk_done) chk({cur.name, "_done_data"}, 32'(memdata_out), 32'(cur.md));
            pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic expect_req(input string nm, input int st, input int we, input int oe,
                            input int rdn, input int wrn, input int en,
                            input logic cb, input logic [15:0] bus,
                            input logic [15:0] md, input logic cd);
    exp_t e;
    e.name = nm; e.stall_n = st; e.we_n = we; e.oe_n = oe; e.rdn_n = rdn;
    e.wrn_n = wrn; e.en_hi = en; e.chk_bus = cb; e.bus = bus; e.md = md; e.chk_done = cd;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    bit done = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) begin done = 1; break; end
    end
    if (!done) chk("req_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    #12;
    // reset state
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_rdn",  32'(uart_rdn), 32'd1);
    chk("rst_wrn",  32'(uart_wrn), 32'd1);
    chk("rst_en_n", 32'(ram_en_n), 32'd0);
    chk("rst_memdata", 32'(memdata_out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    force_drv = 1'b1; #1;
    chk("rst_bus_released", 32'(ram_data), 32'h3C3C);
    force_drv = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    expect_req("sram_store", 2, 1, 0, 0, 0, 0, 1'b1, 16'hBEEF, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, 16'h1234, 16'hBEEF);
    expect_req("sram_load", 2, 0, 1, 0, 0, 0, 1'b0, 16'h0, 16'hBEEF, 1'b1);
    issue(1'b1, 1'b0, 16'h1234, 16'h0000);

`ifdef MEM_CTRL_UART_EN
    uart_data_ready = 1'b1; uart_tbre = 1'b1; tsre_force_low = 1'b1;
    expect_req("status_read", 0, 0, 0, 0, 0, 0, 1'b0, 16'h0, 16'h0002, 1'b0);
    issue(1'b1, 1'b0, 16'hBF01, 16'h0000);
    expect_req("status_write", 0, 0, 0, 0, 0, 0, 1'b0, 16'h0, 16'h0002, 1'b0);
    issue(1'b0, 1'b1, 16'hBF01, 16'hFFFF);
    tsre_force_low = 1'b0; uart_data_ready = 1'b0;
    expect_req("uart_write", 7, 0, 0, 0, 1, 6, 1'b1, 16'h0041, 16'h0002, 1'b0);
    issue(1'b0, 1'b1, 16'hBF00, 16'h0041);
    expect_req("uart_read", 2, 0, 0, 1, 0, 1, 1'b0, 16'h0, 16'h005A, 1'b1);
    issue(1'b1, 1'b0, 16'hBF00, 16'h0000);
    expect_req("both_bits_write", 2, 1, 0, 0, 0, 0, 1'b1, 16'h1357, 16'h005A, 1'b0);
`else
    expect_req("bf00_sram_write", 2, 1, 0, 0, 0, 0, 1'b1, 16'h0041, 16'hBEEF, 1'b0);
    issue(1'b0, 1'b1, 16'hBF00, 16'h0041);
    expect_req("bf00_sram_read", 2, 0, 1, 0, 0, 0, 1'b0, 16'h0, 16'h0041, 1'b1);
    issue(1'b1, 1'b0, 16'hBF00, 16'h0000);
    expect_req("both_bits_write", 2, 1, 0, 0, 0, 0, 1'b1, 16'h1357, 16'h0041, 1'b0);
`endif
    issue(1'b1, 1'b1, 16'h2000, 16'h1357);
    expect_req("load_after_both", 2, 0, 1, 0, 0, 0, 1'b0, 16'h0, 16'h1357, 1'b1);
    issue(1'b1, 1'b0, 16'h2000, 16'h0000);

    // reset asserted while the write strobe is active
    begin
      bit seen = 0;
      @(posedge clk); #1;
      mem_write = 1'b1; addr = 16'h3000; wdata = 16'h7777;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!ram_we_n) begin seen = 1; break; end
      end
      chk("midrst_saw_we", 32'(seen), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("midrst_we_n", 32'(ram_we_n), 32'd1);
      chk("midrst_stall", 32'(stall), 32'd0);
      chk("midrst_memdata", 32'(memdata_out), 32'd0);
      mem_write = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
    end
    expect_req("load_after_reset", 2, 0, 1, 0, 0, 0, 1'b0, 16'h0, 16'hBEEF, 1'b1);
    issue(1'b1, 1'b0, 16'h1234, 16'h0000);

    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
